// File: rtl/multicycle_cu.sv
// multicycle_cu: Moore control sequencer for the 16-bit multi-cycle CPU datapath.
// Steps the shared ALU, register file, IR and unified memory through
// fetch / decode / execute / memory / writeback for R-format, LW, SW and BEQ.
// Memory states wait on mem_ready and give up after WAIT_LIMIT idle cycles
// (WAIT_LIMIT = 0 waits forever).
// Optional feature: define CU_JUMP_EN to add the J instruction (opcode 000010).
module multicycle_cu #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMRD    = 4'd4,
        MEMWB    = 4'd5,
        MEMWR    = 4'd6,
        RTYPE_EX = 4'd7,
        RTYPE_WB = 4'd8,
        BEQ_EX   = 4'd9,
        JUMP     = 4'd10,
        HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Counter only has to reach WAIT_LIMIT-1 before the timeout fires.
    localparam int unsigned CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 32'd1);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [5:0]    opcode_q, opcode_d;
    logic          illegal_op_q, illegal_op_d;
    logic          mem_timeout_q, mem_timeout_d;
    logic          wait_hit_s;
    state_t        done_next_s;

    // State, wait counter, latched opcode and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            opcode_q      <= 6'd0;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            opcode_q      <= opcode_d;
            illegal_op_q  <= illegal_op_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state selection, wait-state timeout and error flag updates.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        opcode_d      = opcode_q;
        illegal_op_d  = illegal_op_q;
        mem_timeout_d = mem_timeout_q;
        wait_hit_s    = (WAIT_LIMIT != 32'd0) && (wait_cnt_q == LIMIT_M1);
        done_next_s   = run ? FETCH : IDLE;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH, MEMRD, MEMWR: begin
                if (mem_ready) begin
                    if (state_q == FETCH) begin
                        state_d = DECODE;
                    end else if (state_q == MEMRD) begin
                        state_d = MEMWB;
                    end else begin
                        state_d = done_next_s;
                    end
                end else if (wait_hit_s) begin
                    state_d       = HALT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DECODE: begin
                opcode_d = opcode;
                case (opcode)
                    OP_RTYPE:     state_d = RTYPE_EX;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BEQ_EX;
`ifdef CU_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default: begin
                        state_d      = HALT;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (opcode_q == OP_LW) begin
                    state_d = MEMRD;
                end else begin
                    state_d = MEMWR;
                end
            end
            RTYPE_EX:                        state_d = RTYPE_WB;
            MEMWB, RTYPE_WB, BEQ_EX, JUMP:   state_d = done_next_s;
            HALT:                            state_d = HALT;
            default:                         state_d = IDLE;
        endcase

        // Every entry into a wait state is a state change, so this clears
        // the counter on entry while letting it count during a stall.
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_d;
        end
    end

    // Moore control decode from the current state (mem_ready gates strobes).
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEMWB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            RTYPE_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BEQ_EX: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

    assign state       = state_q;
    assign illegal_op  = illegal_op_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed bench for multicycle_cu, built with WAIT_LIMIT = 3.
module tb_multicycle_cu;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic mem_ready = 1'b0;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg;
    logic RegDst, RegWrite, ALUSrcA, instr_done, illegal_op, mem_timeout;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic [16:0] ctl;

    int checks = 0;
    int failures = 0;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_MA = 4'd3,
                           S_MR = 4'd4, S_MWB = 4'd5, S_MW = 4'd6, S_REX = 4'd7,
                           S_RWB = 4'd8, S_BEQ = 4'd9, S_JMP = 4'd10, S_HALT = 4'd15;

    // {PCW,PCWC,IorD,MR,MW,IRW,M2R,RD,RW,SA}_{ALUSrcB}_{ALUOp}_{PCSource}_{done}
    localparam logic [16:0] C_ZERO = 17'b0000000000_00_00_00_0;
    localparam logic [16:0] C_F1   = 17'b1001010000_01_00_00_0;
    localparam logic [16:0] C_F0   = 17'b0001000000_01_00_00_0;
    localparam logic [16:0] C_DEC  = 17'b0000000000_11_00_00_0;
    localparam logic [16:0] C_MA   = 17'b0000000001_10_00_00_0;
    localparam logic [16:0] C_MR   = 17'b0011000000_00_00_00_0;
    localparam logic [16:0] C_MWB  = 17'b0000001010_00_00_00_1;
    localparam logic [16:0] C_MW1  = 17'b0010100000_00_00_00_1;
    localparam logic [16:0] C_MW0  = 17'b0010100000_00_00_00_0;
    localparam logic [16:0] C_REX  = 17'b0000000001_00_10_00_0;
    localparam logic [16:0] C_RWB  = 17'b0000000110_00_00_00_1;
    localparam logic [16:0] C_BEQ  = 17'b0100000001_00_01_01_1;
    localparam logic [16:0] C_JMP  = 17'b1000000000_00_00_10_1;

    multicycle_cu #(.WAIT_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .instr_done(instr_done),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        run = 1'b1; mem_ready = 1'b1;
        do_reset();
        run = 1'b0;
        #1;
        checks++;
        if ({state, ctl, illegal_op, mem_timeout} !== {S_IDLE, C_ZERO, 2'b00}) begin
            failures++;
            $display("FAIL reset: state=%0d ctl=%b flags=%b%b expected state=0 ctl=0 flags=00",
                     state, ctl, illegal_op, mem_timeout);
        end
        tick();
        checks++;
        if (state !== S_IDLE) begin
            failures++;
            $display("FAIL idle_hold: state=%0d expected 0", state);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  st[4] = '{S_FETCH, S_DEC, S_REX, S_RWB};
        logic [16:0] cv[4] = '{C_F1, C_DEC, C_REX, C_RWB};
        int dones = 0;
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== st[i] || ctl !== cv[i]) begin
                failures++;
                $display("FAIL rtype[%0d]: state=%0d ctl=%b expected state=%0d ctl=%b",
                         i, state, ctl, st[i], cv[i]);
            end
            if (instr_done) dones++;
            tick();
        end
        checks++;
        if (state !== S_FETCH || dones != 1) begin
            failures++;
            $display("FAIL rtype_end: state=%0d dones=%0d expected state=1 dones=1", state, dones);
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0]  st[7] = '{S_FETCH, S_DEC, S_MA, S_MR, S_MR, S_MR, S_MWB};
        logic [16:0] cv[7] = '{C_F1, C_DEC, C_MA, C_MR, C_MR, C_MR, C_MWB};
        logic        rd[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b100011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rd[i];
            #1;
            checks++;
            if (state !== st[i] || ctl !== cv[i]) begin
                failures++;
                $display("FAIL lw[%0d]: state=%0d ctl=%b expected state=%0d ctl=%b",
                         i, state, ctl, st[i], cv[i]);
            end
            tick();
        end
        checks++;
        if (state !== S_FETCH || mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL lw_end: state=%0d timeout=%b expected state=1 timeout=0",
                     state, mem_timeout);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  st[8] = '{S_FETCH, S_DEC, S_MA, S_MW, S_MW, S_FETCH, S_DEC, S_BEQ};
        logic [16:0] cv[8] = '{C_F1, C_DEC, C_MA, C_MW0, C_MW1, C_F1, C_DEC, C_BEQ};
        logic        rd[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0]  op[8] = '{6'b101011, 6'b101011, 6'b000100, 6'b000100,
                               6'b000100, 6'b000100, 6'b000100, 6'b100011};
        for (int i = 0; i < 8; i++) begin
            mem_ready = rd[i];
            opcode = op[i];
            #1;
            checks++;
            if (state !== st[i] || ctl !== cv[i]) begin
                failures++;
                $display("FAIL b2b[%0d]: state=%0d ctl=%b expected state=%0d ctl=%b",
                         i, state, ctl, st[i], cv[i]);
            end
            tick();
        end
        checks++;
        if (state !== S_FETCH) begin
            failures++;
            $display("FAIL b2b_end: state=%0d expected 1", state);
        end
    endtask

    task automatic test_run_drop();
        logic [3:0]  st[4] = '{S_FETCH, S_DEC, S_REX, S_RWB};
        logic [16:0] cv[4] = '{C_F1, C_DEC, C_REX, C_RWB};
        logic        rn[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1;
            run = rn[i];
            #1;
            checks++;
            if (state !== st[i] || ctl !== cv[i]) begin
                failures++;
                $display("FAIL run_drop[%0d]: state=%0d ctl=%b expected state=%0d ctl=%b",
                         i, state, ctl, st[i], cv[i]);
            end
            tick();
        end
        checks++;
        if (state !== S_IDLE || ctl !== C_ZERO) begin
            failures++;
            $display("FAIL run_drop_end: state=%0d ctl=%b expected state=0 ctl=0", state, ctl);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b111111;
        tick();
        tick();
        tick();
        #1;
        checks++;
        if (state !== S_HALT || illegal_op !== 1'b1 || ctl !== C_ZERO) begin
            failures++;
            $display("FAIL illegal: state=%0d illegal=%b ctl=%b expected state=15 illegal=1 ctl=0",
                     state, illegal_op, ctl);
        end
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            tick();
        end
        checks++;
        if (state !== S_HALT || illegal_op !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold: state=%0d illegal=%b expected state=15 illegal=1",
                     state, illegal_op);
        end
        do_reset();
        checks++;
        if (state !== S_IDLE || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset: state=%0d illegal=%b expected state=0 illegal=0",
                     state, illegal_op);
        end
    endtask

    task automatic test_timeout();
        logic        rd[3] = '{1'b0, 1'b0, 1'b1};
        logic [16:0] cv[3] = '{C_F0, C_F0, C_F1};
        run = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== S_FETCH || ctl !== C_F0) begin
                failures++;
                $display("FAIL tmo_wait[%0d]: state=%0d ctl=%b expected state=1 ctl=%b",
                         i, state, ctl, C_F0);
            end
            tick();
        end
        checks++;
        if (state !== S_HALT || mem_timeout !== 1'b1 || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL timeout: state=%0d tmo=%b ill=%b expected state=15 tmo=1 ill=0",
                     state, mem_timeout, illegal_op);
        end
        do_reset();
        checks++;
        if (mem_timeout !== 1'b0 || state !== S_IDLE) begin
            failures++;
            $display("FAIL tmo_reset: state=%0d tmo=%b expected state=0 tmo=0", state, mem_timeout);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = rd[i];
            #1;
            checks++;
            if (state !== S_FETCH || ctl !== cv[i]) begin
                failures++;
                $display("FAIL tmo_edge[%0d]: state=%0d ctl=%b expected state=1 ctl=%b",
                         i, state, ctl, cv[i]);
            end
            tick();
        end
        checks++;
        if (state !== S_DEC || mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL tmo_ready_wins: state=%0d tmo=%b expected state=2 tmo=0",
                     state, mem_timeout);
        end
        // Reset while stalled in FETCH: no strobes after the edge.
        do_reset();
        tick();
        mem_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (state !== S_IDLE || ctl !== C_ZERO) begin
            failures++;
            $display("FAIL reset_mid_wait: state=%0d ctl=%b expected state=0 ctl=0", state, ctl);
        end
    endtask

    task automatic test_jump();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b000010;
        tick();
        tick();
        tick();
        #1;
        checks++;
`ifdef CU_JUMP_EN
        if (state !== S_JMP || ctl !== C_JMP) begin
            failures++;
            $display("FAIL jump: state=%0d ctl=%b expected state=10 ctl=%b", state, ctl, C_JMP);
        end
`else
        if (state !== S_HALT || illegal_op !== 1'b1) begin
            failures++;
            $display("FAIL jump_illegal: state=%0d illegal=%b expected state=15 illegal=1",
                     state, illegal_op);
        end
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_run_drop();
        test_illegal();
        test_timeout();
        test_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multi-cycle control sequencer for the 16-bit CPU datapath. It replaces single-cycle opcode decoding with a Moore state machine that steps the shared ALU, register file, instruction register and unified memory through fetch, decode, execute, memory and writeback. It supports R-format, LW, SW and BEQ, and optionally J. Memory accesses use a ready handshake with a bounded wait timeout.

## Interface
- WAIT_LIMIT, 15: maximum consecutive cycles a memory state waits without `mem_ready` before timing out; 0 disables the timeout.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and clears all flags.
- run  in  1  enables instruction sequencing.
- opcode  in  6  instruction bits [15:10] from the IR; sampled only in DECODE.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  ALU B operand: 00=reg B, 01=constant 1, 10=sign-extended immediate, 11=immediate branch offset.
- ALUOp  out  2  00=add, 01=subtract (compare), 10=function-field decode.
- PCSource  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target.
- state  out  4  current state code.
- instr_done  out  1  high in the final cycle of each instruction.
- illegal_op, mem_timeout  out  1 each  sticky error flags.

## Operation
- State codes: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, RTYPE_EX=7, RTYPE_WB=8, BEQ_EX=9, JUMP=10, HALT=15.
- Outputs are a pure function of `state` and `mem_ready`. Every control not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH when `run`=1.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite equal `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 000000 → RTYPE_EX
  - 100011 or 101011 → MEMADR
  - 000100 → BEQ_EX
  - any other opcode → HALT with illegal_op set.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for LW, MEMWR for SW; the opcode is latched in DECODE.
- MEMRD: MemRead=1, IorD=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1, instr_done=1.
- MEMWR: MemWrite=1, IorD=1. Waits for `mem_ready`; instr_done equals `mem_ready`.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RTYPE_WB.
- RTYPE_WB: RegDst=1, MemToReg=0, RegWrite=1, instr_done=1.
- BEQ_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1.
- Exit from any instr_done cycle: FETCH if `run`=1, otherwise IDLE. Deasserting `run` mid-instruction never aborts it.
- HALT: all controls 0. Exited only by reset. illegal_op and mem_timeout hold until reset.

## Timing
- Latency from entering FETCH to instr_done, with zero wait states: R=4, LW=5, SW=4, BEQ=3, J=3 cycles.
- Each cycle a wait state (FETCH, MEMRD, MEMWR) sees `mem_ready`=0 adds one cycle.
- wait_cnt clears on entering a wait state and increments each cycle `mem_ready`=0 there.
- Timeout: if `mem_ready`=0 while wait_cnt==WAIT_LIMIT-1, the next state is HALT and mem_timeout is set.
- `mem_ready`=1 in the limit cycle wins over the timeout and completes normally.
- `mem_ready` is ignored outside wait states.
- Reset values: state=IDLE (0), all controls 0, instr_done=0, illegal_op=0, mem_timeout=0, wait_cnt=0, latched opcode=0.
- Reset asserted in any state, including mid-wait or HALT, takes effect at the next edge, and no write strobe is asserted in that cycle after the edge.

## Configuration
- CU_JUMP_EN defined:
  - opcode 000010 in DECODE goes to JUMP.
  - JUMP: PCWrite=1, PCSource=10, instr_done=1.
- CU_JUMP_EN undefined:
  - opcode 000010 is illegal (goes to HALT with illegal_op set).
  - state code 10 is never reached.

## Test plan
- Reset, `run`=1, `mem_ready`=1, opcode=000000 → states 1,2,7,8,1. RegWrite=1 and RegDst=1 only in state 8; instr_done pulses once.
- LW (100011) with `mem_ready` low for 2 cycles in MEMRD → MEMRD lasts 3 cycles, then MEMWB with MemToReg=1 and RegWrite=1; total 7 cycles.
- SW (101011), then BEQ (000100) back to back → MemWrite=1 only in MEMWR; PCWriteCond=1 and ALUOp=01 in BEQ_EX; FETCH follows directly with no IDLE.
- Opcode 111111 → HALT (15) and illegal_op=1 after DECODE. Stays in HALT with `run`=1 until reset; reset returns to state 0 with flags cleared.
- WAIT_LIMIT=3, `mem_ready` held 0 in FETCH → HALT after exactly 3 FETCH cycles with mem_timeout=1. Ready on the 3rd cycle → DECODE instead.
- `run` dropped during RTYPE_EX → RTYPE_WB completes, then IDLE. Opcode 000010 → JUMP with PCSource=10 if CU_JUMP_EN is defined, otherwise HALT.
